sprite_rom_arbiter: RTL and testbench

//   Shares one synchronous sprite/base ROM read port among NUM_REQ renderers
//   (background, tank sprites, base sprites) on the VGA pixel clock.

---
 rtl/sprite_rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ renderers.
// Each grant is returned to its owner as a tagged rvalid pulse ROM_LAT cycles later.
module sprite_rom_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8,
    parameter int ROM_LAT  = 1,
    parameter int PRIO0    = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        starve,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);

    logic [IDX_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_pipe_vld [ROM_LAT];
    logic [IDX_W-1:0]  r_pipe_idx [ROM_LAT];

    logic [ADDR_W-1:0] w_addr  [NUM_REQ];
    logic [IDX_W-1:0]  w_scan  [NUM_REQ];
    logic [NUM_REQ-1:0] w_cand;
    logic              w_prio_hit;
    logic              w_any;
    logic              w_grant;
    logic [IDX_W-1:0]  w_winner;

    genvar gi;

    // Scan order starts at rr_ptr and wraps; requester 0 is left out of the
    // scan when it has its own fixed-priority path.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [IDX_W:0] w_sum;
            assign w_addr[gi] = addr[gi*ADDR_W +: ADDR_W];
            assign w_sum      = {1'b0, r_rr_ptr} + (IDX_W+1)'(gi);
            assign w_scan[gi] = (w_sum >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                              : w_sum[IDX_W-1:0];
            assign w_cand[gi] = req[w_scan[gi]] &&
                                !((PRIO0 != 0) && (w_scan[gi] == '0));
        end
    endgenerate

    always_comb begin
        w_prio_hit = (PRIO0 != 0) && req[0];
        w_any      = 1'b0;
        w_winner   = '0;
        if (w_prio_hit) begin
            w_any    = 1'b1;
            w_winner = '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_any && w_cand[k]) begin
                    w_any    = 1'b1;
                    w_winner = w_scan[k];
                end
            end
        end
    end

    assign w_grant = w_any && !Reset;

    always_comb begin
        gnt = '0;
        if (w_grant) gnt[w_winner] = 1'b1;
    end

    // The ROM registers its address, so present the winner's address in the
    // grant cycle and otherwise hold the last one issued.
    assign rom_address = w_grant ? w_addr[w_winner] : r_last_addr;
    assign rdata       = rom_q;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_rr_ptr    <= '0;
            r_last_addr <= '0;
        end else if (w_grant) begin
            r_last_addr <= w_addr[w_winner];
            if (!w_prio_hit)
                r_rr_ptr <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    // Return pipe: one slot per ROM latency cycle, tagged with the owner.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            for (int s = 0; s < ROM_LAT; s++) begin
                r_pipe_vld[s] <= 1'b0;
                r_pipe_idx[s] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_grant;
            r_pipe_idx[0] <= w_winner;
            for (int s = 1; s < ROM_LAT; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                r_pipe_idx[s] <= r_pipe_idx[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (!Reset && r_pipe_vld[ROM_LAT-1]) rvalid[r_pipe_idx[ROM_LAT-1]] = 1'b1;
    end

    // Per-requester wait counters; starve is sticky until Reset.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_wait
            logic [WAIT_W-1:0] r_wait_cnt;
            logic              r_starve;
            logic [WAIT_W-1:0] w_wait_next;

            assign w_wait_next = (!req[gi] || gnt[gi]) ? '0
                               : (r_wait_cnt == WAIT_SAT) ? WAIT_SAT
                               : r_wait_cnt + 1'b1;

            always_ff @(posedge vga_clk) begin
                if (Reset) begin
                    r_wait_cnt <= '0;
                    r_starve   <= 1'b0;
                end else begin
                    r_wait_cnt <= w_wait_next;
                    if (w_wait_next == WAIT_SAT) r_starve <= 1'b1;
                end
            end

            assign starve[gi] = r_starve;
        end
    endgenerate

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: a round-robin instance (ROM_LAT=2) and a priority
// instance (ROM_LAT=1) share stimulus; directed tables plus a reference model.
module tb_sprite_rom_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr;

    logic [N-1:0]  gnt_a, rv_a, st_a, gnt_b, rv_b, st_b;
    logic [DW-1:0] rd_a, rd_b, rq_a, rq_b, rom_a1;
    logic [AW-1:0] ra_a, ra_b;

    int errors = 0;
    int checks = 0;

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2),
                         .PRIO0(0), .MAX_WAIT(MW)) u_rr (
        .vga_clk(clk), .Reset(rst), .req(req), .addr(addr), .gnt(gnt_a),
        .rvalid(rv_a), .rdata(rd_a), .starve(st_a), .rom_address(ra_a), .rom_q(rq_a));

    sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1),
                         .PRIO0(1), .MAX_WAIT(MW)) u_pr (
        .vga_clk(clk), .Reset(rst), .req(req), .addr(addr), .gnt(gnt_b),
        .rvalid(rv_b), .rdata(rd_b), .starve(st_b), .rom_address(ra_b), .rom_q(rq_b));

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = (a * 10'd7) + 10'h035;
        return t[DW-1:0];
    endfunction

    // Synchronous ROMs with the latency each instance was built for.
    always @(posedge clk) begin
        rom_a1 <= rom_fn(ra_a);
        rq_a   <= rom_a1;
        rq_b   <= rom_fn(ra_b);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            inst;
        int            due;
        int            idx;
        logic [AW-1:0] a;
    } ret_t;

    ret_t          pend[$];
    int            m_rr [2];
    logic [AW-1:0] m_last [2];
    int            m_wc [2][N];
    logic [N-1:0]  m_st [2];
    int            cyc = 0;
    bit            model_on = 0;

    function automatic int lat_of(input int n);
        return (n == 0) ? 2 : 1;
    endfunction

    function automatic bit prio_of(input int n);
        return (n == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic int pick(input int n, input logic [N-1:0] r);
        if (prio_of(n) && r[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr[n] + k) % N;
            if (!(prio_of(n) && j == 0) && r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 2; n++) begin
            m_rr[n] = 0;
            m_last[n] = '0;
            m_st[n] = '0;
            for (int i = 0; i < N; i++) m_wc[n][i] = 0;
        end
        pend.delete();
    endtask

    logic [N-1:0]  o_g, o_rv, o_st, e_g, e_rv;
    logic [DW-1:0] o_rd, e_rd;
    logic [AW-1:0] o_ra, e_ra;
    int            m_w;
    bit            m_has;
    string         pfx;

    always @(negedge clk) begin
        if (model_on) begin
            for (int n = 0; n < 2; n++) begin
                pfx  = (n == 0) ? "rr" : "pr";
                o_g  = (n == 0) ? gnt_a : gnt_b;
                o_rv = (n == 0) ? rv_a  : rv_b;
                o_st = (n == 0) ? st_a  : st_b;
                o_rd = (n == 0) ? rd_a  : rd_b;
                o_ra = (n == 0) ? ra_a  : ra_b;
                m_w  = rst ? -1 : pick(n, req);
                e_g  = '0;
                if (m_w >= 0) e_g[m_w] = 1'b1;
                e_ra = (m_w >= 0) ? addr[m_w*AW +: AW] : m_last[n];
                e_rv = '0;
                e_rd = '0;
                m_has = 0;
                foreach (pend[q]) begin
                    if (!rst && pend[q].inst == n && pend[q].due == cyc) begin
                        e_rv[pend[q].idx] = 1'b1;
                        e_rd = rom_fn(pend[q].a);
                        m_has = 1;
                    end
                end
                chk({pfx, "_gnt"}, 32'(o_g), 32'(e_g));
                chk({pfx, "_romaddr"}, 32'(o_ra), 32'(e_ra));
                chk({pfx, "_rvalid"}, 32'(o_rv), 32'(e_rv));
                chk({pfx, "_starve"}, 32'(o_st), 32'(m_st[n]));
                if (m_has) chk({pfx, "_rdata"}, 32'(o_rd), 32'(e_rd));

                if (!rst) begin
                    if (m_w >= 0) begin
                        pend.push_back('{n, cyc + lat_of(n), m_w, addr[m_w*AW +: AW]});
                        m_last[n] = addr[m_w*AW +: AW];
                        if (!(prio_of(n) && m_w == 0)) m_rr[n] = (m_w + 1) % N;
                    end
                    for (int i = 0; i < N; i++) begin
                        if (!req[i] || m_w == i) m_wc[n][i] = 0;
                        else if (m_wc[n][i] < MW + 1) m_wc[n][i]++;
                        if (m_wc[n][i] == MW + 1) m_st[n][i] = 1'b1;
                    end
                end
            end
            if (rst) model_clear();
            else
                for (int q = pend.size() - 1; q >= 0; q--)
                    if (pend[q].due <= cyc) pend.delete(q);
            cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] v);
        addr[i*AW +: AW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] g_rr;
        logic [N-1:0] g_pr;
    } vec_t;

    vec_t vt [17];

    initial begin
        for (int v = 0; v < 8; v++) vt[v] = '{4'b1111, 4'b0001 << (v % 4), 4'b0001};
        vt[8]  = '{4'b1110, 4'b0010, 4'b0010};
        vt[9]  = '{4'b1010, 4'b1000, 4'b1000};
        vt[10] = '{4'b0001, 4'b0001, 4'b0001};
        vt[11] = '{4'b0000, 4'b0000, 4'b0000};
        vt[12] = '{4'b0101, 4'b0100, 4'b0001};
        vt[13] = '{4'b0100, 4'b0100, 4'b0100};
        vt[14] = '{4'b1001, 4'b1000, 4'b0001};
        vt[15] = '{4'b1001, 4'b0001, 4'b0001};
        vt[16] = '{4'b1000, 4'b1000, 4'b1000};

        model_clear();
        rst  = 1'b1;
        req  = '0;
        addr = '0;
        model_on = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("idle_gnt", 32'({gnt_a, gnt_b}), 32'h0);
            chk("idle_rvalid", 32'({rv_a, rv_b}), 32'h0);
            chk("idle_starve", 32'({st_a, st_b}), 32'h0);
            chk("idle_romaddr", 32'({ra_a, ra_b}), 32'h0);
            step();
        end

        // Single requester 2, back-to-back addresses 0x010..0x013
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                req = 4'b0100;
                set_addr(2, 10'(16 + k));
            end else req = '0;
            sample();
            chk("solo_gnt_pr", 32'(gnt_b), (k < 4) ? 32'h4 : 32'h0);
            chk("solo_gnt_rr", 32'(gnt_a), (k < 4) ? 32'h4 : 32'h0);
            chk("solo_rv_pr", 32'(rv_b), (k >= 1 && k <= 4) ? 32'h4 : 32'h0);
            chk("solo_rv_rr", 32'(rv_a), (k >= 2) ? 32'h4 : 32'h0);
            if (k >= 1 && k <= 4) chk("solo_rd_pr", 32'(rd_b), 32'(rom_fn(10'(16 + k - 1))));
            if (k >= 2) chk("solo_rd_rr", 32'(rd_a), 32'(rom_fn(10'(16 + k - 2))));
            step();
        end

        // Grant-order table from a fresh rr_ptr
        do_reset();
        for (int v = 0; v < 17; v++) begin
            req = vt[v].r;
            for (int i = 0; i < N; i++) set_addr(i, 10'($urandom));
            sample();
            chk($sformatf("tbl%0d_gnt_rr", v), 32'(gnt_a), 32'(vt[v].g_rr));
            chk($sformatf("tbl%0d_gnt_pr", v), 32'(gnt_b), 32'(vt[v].g_pr));
            step();
        end

        // Priority hog: requesters 1 and 3 starve at their 16th waiting cycle
        do_reset();
        req = 4'b1011;
        for (int k = 0; k <= 16; k++) begin
            sample();
            chk("hog_gnt_pr", 32'(gnt_b), 32'h1);
            chk("hog_starve_pr", 32'(st_b), (k >= 16) ? 32'ha : 32'h0);
            step();
        end
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("alt_gnt_pr", 32'(gnt_b), (k % 2 == 0) ? 32'h2 : 32'h8);
            chk("alt_starve_pr", 32'(st_b), 32'ha);
            chk("alt_starve_rr", 32'(st_a), 32'h0);
            step();
        end
        do_reset();
        sample();
        chk("rst_starve_pr", 32'(st_b), 32'h0);
        step();

        // Reset while a ROM_LAT=2 read is in flight
        req = 4'b0010;
        set_addr(1, 10'h2ab);
        sample();
        chk("flight_gnt_rr", 32'(gnt_a), 32'h2);
        step();
        rst = 1'b1;
        req = '0;
        sample();
        chk("flight_rv_rst", 32'(rv_a), 32'h0);
        step();
        rst = 1'b0;
        sample();
        chk("flight_rv_dropped", 32'(rv_a), 32'h0);
        step();
        req = 4'b0010;
        set_addr(1, 10'h155);
        sample();
        chk("post_gnt_rr", 32'(gnt_a), 32'h2);
        step();
        req = '0;
        sample();
        chk("post_rv_early", 32'(rv_a), 32'h0);
        step();
        sample();
        chk("post_rv_rr", 32'(rv_a), 32'h2);
        chk("post_rd_rr", 32'(rd_a), 32'(rom_fn(10'h155)));
        step();

        // Random traffic, second half biased so requester 0 hogs the priority port
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 79) == 0);
            req = 4'($urandom);
            if (k >= 300) req[0] = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < N; i++) set_addr(i, 10'($urandom));
            step();
        end
        rst = 1'b0;
        req = '0;
        repeat (4) step();
        model_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
